// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the BCD<->binary conversion paths.
//   state_e    : converter FSM states
//   BCD_MAX    : largest legal BCD digit
//   ADJ_THRESH : digit value at or above which reverse double-dabble corrects
//   ADJ_VAL    : correction subtracted from such a digit
//   bcd_valid  : 1 when a nibble is a legal BCD digit
package bcd_pkg;

  typedef enum logic [0:0] {IDLE, SHIFT} state_e;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_VAL    = 4'd3;

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction cell (combinational).
//   digit_i : BCD digit nibble after the right shift
//   digit_o : digit_i - 3 when digit_i >= 8, else digit_i (4-bit, no borrow out)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // A digit >= 8 after shifting means a tens-of-previous-digit (10) landed
  // here as 8; subtracting 3 turns it back into a weight-5 correction.
  assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_VAL) : digit_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one reverse double-dabble
// iteration per clock.
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset
//   start   : conversion request, accepted only when idle
//   bcd_in  : packed BCD, most significant digit in the top nibble
//   busy    : conversion in progress
//   done    : one-cycle pulse, bin_out/err valid
//   bin_out : binary result, held until the next done
//   err     : last request contained a digit > 9, held until the next done
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned OUT_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned WW   = BcdW + OUT_W;
  localparam int unsigned CntW = $clog2(OUT_W + 1);

  state_e            state_q, state_d;
  logic [WW-1:0]     w_q, w_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [OUT_W-1:0]  bin_q, bin_d;

  logic [WW-1:0]     w_shr;
  logic [WW-1:0]     w_adj;
  logic              all_valid;
  logic              last_iter;

  // Working register: BCD digit field on top, binary field accumulates below.
  assign w_shr = w_q >> 1;
  assign w_adj[OUT_W-1:0] = w_shr[OUT_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (w_shr[OUT_W+4*g +: 4]),
      .digit_o (w_adj[OUT_W+4*g +: 4])
    );
  end

  always_comb begin
    all_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(bcd_in[4*i +: 4])) begin
        all_valid = 1'b0;
      end
    end
  end

  assign last_iter = (cnt_q == CntW'(OUT_W - 1));

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (all_valid) begin
            w_d     = {bcd_in, {OUT_W{1'b0}}};
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            // Illegal digit: report immediately, never go busy.
            done_d = 1'b1;
            err_d  = 1'b1;
            bin_d  = '0;
          end
        end
      end
      SHIFT: begin
        w_d   = w_adj;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          bin_d   = w_adj[OUT_W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

  // Legal input always drains the digit field completely by the last iteration.
  digit_field_drained: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == SHIFT && last_iter) |-> (w_adj[WW-1:OUT_W] == '0));

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned OUT_W  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic       busy;
  logic       done;
  logic [6:0] bin_out;
  logic       err;

  bcd_to_bin #(
    .DIGITS (DIGITS),
    .OUT_W  (OUT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; edge numbers are used as timestamps.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int bin;
    int err;
    int at_edge;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   free_edge = 0;    // first edge at which the converter will accept start
  int   last_k = -1000;   // accepting edge of the most recent valid request
  int   held_bin = 0;
  int   held_err = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    check("busy", int'(busy), int'(cyc >= last_k && cyc <= last_k + int'(OUT_W) - 1));
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("bin_out", int'(bin_out), e.bin);
        check("err", int'(err), e.err);
        check("done_edge", cyc, e.at_edge);
        held_bin = e.bin;
        held_err = e.err;
      end
    end
    check("bin_out_held", int'(bin_out), held_bin);
    check("err_held", int'(err), held_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; the model decides whether it is accepted.
  task automatic issue(input logic [7:0] v);
    int   k;
    exp_t e;
    k = cyc + 1;
    start  = 1'b1;
    bcd_in = v;
    if (k >= free_edge) begin
      if (v[7:4] <= 4'd9 && v[3:0] <= 4'd9) begin
        e.bin     = 10 * int'(v[7:4]) + int'(v[3:0]);
        e.err     = 0;
        e.at_edge = k + int'(OUT_W);
        free_edge = k + int'(OUT_W) + 1;
        last_k    = k;
      end else begin
        e.bin     = 0;
        e.err     = 1;
        e.at_edge = k;
        free_edge = k + 1;
      end
      q.push_back(e);
    end
    tick();
    start  = 1'b0;
    bcd_in = 8'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && cyc + 1 >= free_edge) break;
      tick();
    end
    if (q.size() != 0) begin
      check("timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic check_reset_state();
    check("rst_bin_out", int'(bin_out), 0);
    check("rst_err", int'(err), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    q.delete();
    last_k    = -1000;
    free_edge = 0;
    held_bin  = 0;
    held_err  = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] code;
    tick();
    do_reset();
    check_reset_state();

    // Directed values
    issue(8'h99); wait_idle();
    issue(8'h00); wait_idle();
    issue(8'h63); wait_idle();
    issue(8'h10); wait_idle();

    // Illegal digit, then a legal one
    issue(8'h3A); wait_idle();
    issue(8'h21); wait_idle();

    // Start while busy is ignored
    issue(8'h45);
    tick(); tick();
    issue(8'h12);
    wait_idle();

    // Reset aborts a conversion in progress
    issue(8'h77);
    tick(); tick(); tick();
    do_reset();
    check_reset_state();
    tick();
    check_reset_state();
    issue(8'h05); wait_idle();

    // Start during the done cycle of the previous conversion
    issue(8'h25);
    for (int i = 0; i < 50; i++) begin
      if (cyc + 1 >= free_edge) break;
      tick();
    end
    issue(8'h50);
    wait_idle();

    // Sweep all legal codes with random gaps and random starts while busy
    for (int i = 0; i < 100; i++) begin
      code = {4'(i / 10), 4'(i % 10)};
      issue(code);
      for (int j = 0; j < int'($urandom_range(0, 9)); j++) begin
        if ($urandom_range(0, 3) == 0) issue(8'($urandom));
        else tick();
      end
      wait_idle();
    end

    // Random codes, legal or not
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom));
      wait_idle();
    end

    tick(); tick();
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
